instruction_loader: RTL and testbench

Program loader that fills the instruction memory before execution. It assembles 8-bit bytes from the UART receiver into 32-bit instruction words. Each word is driven onto the memory's load port (o_loading / o_address / o_instruccion) with a one-cycle write strobe. Loading stops after a HALT-opcode word is written or the memory is full; the loader then reports completion to the debug/control unit.

---
 rtl/instruction_loader_if.sv | 27 ++
 rtl/instruction_loader.sv | 108 ++++++++++
 tb/tb_instruction_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Loader-side bus: start/byte stream in, memory load port and status out.
interface instruction_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic                  i_start;
  logic [BYTE_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;
  logic                  o_done;
  logic                  o_overflow;
  logic [DATA_WIDTH-1:0] o_word_count;

  // Controller / UART side drives the byte stream and start pulse.
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_instruccion, o_address, o_loading, o_done, o_overflow, o_word_count
  );

  // Loader side.
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_instruccion, o_address, o_loading, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: packs MSB-first UART bytes into words and writes them
// to instruction memory until a HALT word is written or memory is full.
module instruction_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int SIZEOP     = 6,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  instruction_loader_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SHW   = DATA_WIDTH - BYTE_WIDTH;
  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_DEPTH - 1);
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t                r_state;
  logic [SHW-1:0]        r_shift;      // first BYTES-1 bytes of the word in flight
  logic [BCW-1:0]        r_bcnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_word_count;
  logic                  r_loading;
  logic                  r_done;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_halt;
  logic                  w_last;

  assign w_word = {r_shift, bus.i_rx_data};
  assign w_halt = &r_instr[DATA_WIDTH-1 -: SIZEOP];
  assign w_last = (r_addr == LAST_ADDR);

  // Loader FSM; every output is a register updated here.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_addr       <= '0;
      r_instr      <= '0;
      r_word_count <= '0;
      r_loading    <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // A new session restarts from address 0; o_instruccion keeps the last word.
          if (bus.i_start) begin
            r_state      <= RECEIVE;
            r_addr       <= '0;
            r_bcnt       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
          end
        end
        RECEIVE: begin
          if (bus.i_rx_valid) begin
            r_shift <= w_word[SHW-1:0];
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == LAST_BYTE) begin
              r_state   <= WRITE;
              r_loading <= 1'b1;
              r_instr   <= w_word;
            end
          end
        end
        WRITE: begin
          // Single-cycle strobe; HALT beats the full-memory check.
          r_loading    <= 1'b0;
          r_word_count <= r_word_count + 1'b1;
          if (w_halt) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_overflow <= 1'b0;
          end else if (w_last) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_overflow <= 1'b1;
          end else begin
            r_state <= RECEIVE;
            r_addr  <= r_addr + 1'b1;
            // A byte landing on the strobe cycle opens the next word.
            if (bus.i_rx_valid) begin
              r_shift <= w_word[SHW-1:0];
              r_bcnt  <= BCW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_instruccion = r_instr;
  assign bus.o_address     = r_addr;
  assign bus.o_loading     = r_loading;
  assign bus.o_done        = r_done;
  assign bus.o_overflow    = r_overflow;
  assign bus.o_word_count  = r_word_count;
endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table vectors, directed multi-cycle cases
// and random sessions scored against a word-list model.
module tb_instruction_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  instruction_loader_if bus ();
  instruction_loader dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Strobe capture: every write seen on the load port, plus back-to-back count.
  logic [63:0] mon_q[$];
  logic        prev_load = 1'b0;
  int          bb_err = 0;
  always @(negedge clk) begin
    if (bus.o_loading === 1'b1) begin
      mon_q.push_back({bus.o_address, bus.o_instruccion});
      if (prev_load) bb_err <= bb_err + 1;
    end
    prev_load <= (bus.o_loading === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All task boundaries sit 1 time unit after a rising edge.
  task automatic do_reset();
    bus.i_start = 1'b0; bus.i_rx_valid = 1'b0; bus.i_rx_data = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_loading", bus.o_loading, 0);
    chk("rst_done",    bus.o_done, 0);
    chk("rst_ovf",     bus.o_overflow, 0);
    chk("rst_addr",    bus.o_address, 0);
    chk("rst_instr",   bus.o_instruccion, 0);
    chk("rst_count",   bus.o_word_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Leaves i_rx_valid high; caller drops it (or sends the next byte at once).
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      bus.i_rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.i_rx_data = b; bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], (k == 0) ? gap : 0);
  endtask

  task automatic idle(input int n);
    bus.i_rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
    logic        done;
  } vec_t;

  vec_t vecs[6];
  int   base;

  // Score a session: words fed in order, expected strobes/status from the rules.
  task automatic score(input string tag, input logic [31:0] words[$], input int base_i);
    logic [63:0] exp_q[$];
    int n = 0;
    bit halted = 0;
    foreach (words[i]) begin
      if (!halted && n < 32) begin
        exp_q.push_back({32'(n), words[i]});
        n++;
        if (words[i][31:26] == 6'h3f) halted = 1;
      end
    end
    chk({tag, "_nstrobes"}, mon_q.size() - base_i, exp_q.size());
    foreach (exp_q[i])
      if (base_i + i < mon_q.size()) chk({tag, "_strobe"}, mon_q[base_i + i], exp_q[i]);
    chk({tag, "_done"},  bus.o_done, (halted || n == 32));
    chk({tag, "_ovf"},   bus.o_overflow, (!halted && n == 32));
    chk({tag, "_count"}, bus.o_word_count, n);
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] w;
    vecs[0] = '{8'h20, 8'h01, 8'h00, 8'h05, 32'h20010005, 1'b0};
    vecs[1] = '{8'hFC, 8'h00, 8'h00, 8'h00, 32'hFC000000, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{8'hFB, 8'hFF, 8'hFF, 8'hFF, 32'hFBFFFFFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 1'b0};
    vecs[5] = '{8'h8C, 8'h22, 8'h00, 8'h04, 32'h8C220004, 1'b0};

    // Single-word vectors: 1-cycle latency, address 0, HALT detection.
    foreach (vecs[i]) begin
      do_reset();
      pulse_start();
      send_byte(vecs[i].b0, 1); send_byte(vecs[i].b1, 0);
      send_byte(vecs[i].b2, 2); send_byte(vecs[i].b3, 0);
      bus.i_rx_valid = 1'b0;
      @(negedge clk);
      chk("vec_loading", bus.o_loading, 1);
      chk("vec_addr",    bus.o_address, 0);
      chk("vec_instr",   bus.o_instruccion, vecs[i].word);
      @(negedge clk);
      chk("vec_strobe_end", bus.o_loading, 0);
      chk("vec_done",    bus.o_done, vecs[i].done);
      chk("vec_ovf",     bus.o_overflow, 0);
      chk("vec_count",   bus.o_word_count, 1);
      @(posedge clk); #1;
    end

    // Three words ending in HALT; later bytes are ignored.
    do_reset(); pulse_start(); base = mon_q.size();
    words = '{32'h20010005, 32'h00221820, 32'hFC000000};
    foreach (words[i]) send_word(words[i], 1);
    idle(3);
    score("halt3", words, base);
    send_word(32'h12345678, 1); idle(3);
    chk("halt3_ignored", mon_q.size() - base, 3);

    // Restart from DONE.
    pulse_start();
    chk("restart_done_drop", bus.o_done, 0);
    chk("restart_count_clr", bus.o_word_count, 0);
    base = mon_q.size();
    words = '{32'hFC000000};
    send_word(words[0], 0); idle(3);
    score("restart", words, base);

    // Fill memory with non-HALT words.
    do_reset(); pulse_start(); base = mon_q.size();
    words = {};
    for (int i = 0; i < 32; i++) words.push_back(32'(i));
    foreach (words[i]) send_word(words[i], 0);
    idle(3);
    score("full", words, base);
    chk("full_addr_hold", bus.o_address, 31);

    // HALT at the last address wins over overflow.
    do_reset(); pulse_start(); base = mon_q.size();
    words = {};
    for (int i = 0; i < 31; i++) words.push_back(32'h01000000 + 32'(i));
    words.push_back(32'hFC0000AA);
    foreach (words[i]) send_word(words[i], 1);
    idle(3);
    score("halt_last", words, base);

    // Byte arriving on the strobe cycle starts the next word.
    do_reset(); pulse_start(); base = mon_q.size();
    words = '{32'h20010005, 32'h8C220004};
    send_word(words[0], 0); send_word(words[1], 0); idle(3);
    score("wr_byte", words, base);

    // Reset mid-word discards it; bytes before start are ignored.
    do_reset(); pulse_start(); base = mon_q.size();
    send_byte(8'h20, 0); send_byte(8'h01, 0);
    bus.i_rx_valid = 1'b0;
    rst_n = 1'b0; #2;
    chk("midrst_loading", bus.o_loading, 0);
    chk("midrst_addr",    bus.o_address, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(3);
    chk("midrst_nostrobe", mon_q.size() - base, 0);
    send_byte(8'hAA, 0); idle(1);
    pulse_start(); base = mon_q.size();
    words = '{32'h11223344};
    send_word(words[0], 0); idle(3);
    score("midrst_after", words, base);

    // Random sessions: random words, HALT density and byte gaps.
    for (int s = 0; s < 8; s++) begin
      int nw, hrate;
      nw    = (s == 0) ? 36 : int'($urandom_range(1, 40));
      hrate = (s < 2) ? 0 : int'($urandom_range(0, 12));
      do_reset(); pulse_start(); base = mon_q.size();
      words = {};
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (hrate != 0 && $urandom_range(0, hrate) == 0) w[31:26] = 6'h3f;
        else if (w[31:26] == 6'h3f) w[26] = 1'b0;
        words.push_back(w);
      end
      foreach (words[i]) begin
        for (int k = 0; k < 4; k++) send_byte(words[i][31-8*k -: 8], int'($urandom_range(0, 2)));
      end
      idle(3);
      score("rand", words, base);
    end

    chk("no_back_to_back", bb_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
